// File: rtl/freq_counter_pkg.sv
// ============================================================================
// Module      : freq_counter_pkg
// Description : Shared types and constants for the multi-channel frequency
//               counter (channel FSM states, synchroniser depth limits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } chan_state_t;

  localparam int c_sync_stages_min = 2;
  localparam int c_sync_stages_max = 3;

  // Out-of-range synchroniser depths are pulled back into the legal window.
  function automatic int clamp_sync_stages(input int n);
    if (n < c_sync_stages_min) return c_sync_stages_min;
    if (n > c_sync_stages_max) return c_sync_stages_max;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_channel.sv
// ============================================================================
// Module      : freq_channel
// Description : One measurement channel: synchroniser, edge detect, saturating
//               phase counter, INIT/ARMED/RUN FSM and optional period averager
//               (built when MCFC_AVG_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_channel
  import freq_counter_pkg::*;
#(
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int AVG_LOG2     = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    FREQ_IN,
  output logic [COUNTER_BITS-1:0] TIME_HIGH,
  output logic [COUNTER_BITS-1:0] TIME_LOW,
  output logic [COUNTER_BITS:0]   PERIOD,
  output logic [COUNTER_BITS:0]   PERIOD_AVG,
  output logic                    VALID,
  output logic                    STUCK,
  output logic                    UPDATE,
  output logic                    AVG_UPDATE
);

  localparam int                    c_sync     = clamp_sync_stages(SYNC_STAGES);
  localparam logic [COUNTER_BITS-1:0] c_cnt_max  = '1;
  localparam logic [COUNTER_BITS-1:0] c_cnt_near = c_cnt_max - 1'b1;
  localparam logic [COUNTER_BITS-1:0] c_cnt_one  = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

  logic [c_sync-1:0]       r_sync;
  logic                    r_prev;
  chan_state_t             r_state;
  logic [COUNTER_BITS-1:0] r_cnt;
  logic [COUNTER_BITS-1:0] r_time_high;
  logic [COUNTER_BITS-1:0] r_time_low;
  logic [COUNTER_BITS:0]   r_period;
  logic                    r_done_high;
  logic                    r_valid;
  logic                    r_stuck;
  logic                    r_update;

  logic                    w_level;
  logic                    w_edge;
  logic                    w_fall;
  logic [COUNTER_BITS:0]   w_period_sum;

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[c_sync-2:0], FREQ_IN};
      r_prev <= r_sync[c_sync-1];
    end
  end

  assign w_level      = r_sync[c_sync-1];
  assign w_edge       = w_level ^ r_prev;
  assign w_fall       = w_edge & ~w_level;
  assign w_period_sum = {1'b0, r_time_high} + {1'b0, r_cnt};

  // A saturated phase is still reported, but the period it belongs to is not
  // trusted: the channel drops back to ARMED and needs a fresh high phase.
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_time_high <= '0;
      r_time_low  <= '0;
      r_period    <= '0;
      r_done_high <= 1'b0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (w_edge) begin
            r_state     <= ST_ARMED;
            r_cnt       <= c_cnt_one;
            r_done_high <= 1'b0;
          end
        end
        default: begin
          if (w_edge) begin
            r_cnt   <= c_cnt_one;
            r_stuck <= 1'b0;
            if (w_fall) begin
              r_time_high <= r_cnt;
              r_done_high <= ~r_stuck;
            end else begin
              r_time_low <= r_cnt;
              if (!r_stuck && (r_state == ST_RUN || r_done_high)) begin
                r_period <= w_period_sum;
                r_update <= 1'b1;
                r_valid  <= 1'b1;
                r_state  <= ST_RUN;
              end
            end
            if (r_stuck) begin
              r_state     <= ST_ARMED;
              r_done_high <= 1'b0;
            end
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_near) begin
              r_stuck <= 1'b1;
              r_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign TIME_HIGH = r_time_high;
  assign TIME_LOW  = r_time_low;
  assign PERIOD    = r_period;
  assign VALID     = r_valid;
  assign STUCK     = r_stuck;
  assign UPDATE    = r_update;

`ifdef MCFC_AVG_EN
  localparam int c_acc_w = COUNTER_BITS + 1 + AVG_LOG2;

  logic [c_acc_w-1:0]    r_acc;
  logic [AVG_LOG2-1:0]   r_avg_cnt;
  logic [COUNTER_BITS:0] r_period_avg;
  logic                  r_avg_update;
  logic [c_acc_w-1:0]    w_acc_sum;

  assign w_acc_sum = r_acc + {{AVG_LOG2{1'b0}}, r_period};

  // Consumes each PERIOD write one cycle after it lands.
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      r_acc        <= '0;
      r_avg_cnt    <= '0;
      r_period_avg <= '0;
      r_avg_update <= 1'b0;
    end else begin
      r_avg_update <= 1'b0;
      if (r_stuck) begin
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end else if (r_update) begin
        r_avg_cnt <= r_avg_cnt + 1'b1;
        if (&r_avg_cnt) begin
          r_period_avg <= w_acc_sum[c_acc_w-1:AVG_LOG2];
          r_avg_update <= 1'b1;
          r_acc        <= '0;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign PERIOD_AVG = r_period_avg;
  assign AVG_UPDATE = r_avg_update;
`else
  assign PERIOD_AVG = r_period;
  assign AVG_UPDATE = r_update;
`endif

endmodule

`default_nettype wire

// File: rtl/multich_freq_counter.sv
// ============================================================================
// Module      : multich_freq_counter
// Description : CHANNELS independent frequency counters packed onto flat
//               result buses. Period averaging is built when MCFC_AVG_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multich_freq_counter
  import freq_counter_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int AVG_LOG2     = 2
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [CHANNELS-1:0]                 FREQ_IN,
  output logic [CHANNELS*COUNTER_BITS-1:0]    TIME_HIGH,
  output logic [CHANNELS*COUNTER_BITS-1:0]    TIME_LOW,
  output logic [CHANNELS*(COUNTER_BITS+1)-1:0] PERIOD,
  output logic [CHANNELS*(COUNTER_BITS+1)-1:0] PERIOD_AVG,
  output logic [CHANNELS-1:0]                 VALID,
  output logic [CHANNELS-1:0]                 STUCK,
  output logic [CHANNELS-1:0]                 UPDATE,
  output logic [CHANNELS-1:0]                 AVG_UPDATE
);

  localparam int c_pw = COUNTER_BITS + 1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    freq_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .SYNC_STAGES  (SYNC_STAGES),
      .AVG_LOG2     (AVG_LOG2)
    ) u_chan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .FREQ_IN    (FREQ_IN[g]),
      .TIME_HIGH  (TIME_HIGH[g*COUNTER_BITS +: COUNTER_BITS]),
      .TIME_LOW   (TIME_LOW[g*COUNTER_BITS +: COUNTER_BITS]),
      .PERIOD     (PERIOD[g*c_pw +: c_pw]),
      .PERIOD_AVG (PERIOD_AVG[g*c_pw +: c_pw]),
      .VALID      (VALID[g]),
      .STUCK      (STUCK[g]),
      .UPDATE     (UPDATE[g]),
      .AVG_UPDATE (AVG_UPDATE[g])
    );
  end

endmodule

`default_nettype wire

// File: doc/multich_freq_counter.md
# multich_freq_counter

Parametrised multi-channel successor to the single-channel frequency counter. It measures the high time, low time and period of `CHANNELS` independent asynchronous inputs, all counted in `CLK` cycles. Each channel synchronises its input, tracks measurement state and detects stuck inputs; an optional period-averaging stage can be compiled in. The block sits between the pad-side test inputs and the readout/serialiser logic, which samples the flat result buses on `UPDATE` strobes.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels (1–16).
- `COUNTER_BITS`, 16: width of the phase counters; saturating.
- `SYNC_STAGES`, 2: synchroniser flops per input (2–3).
- `AVG_LOG2`, 2: log2 of the number of periods averaged. Used only with `MCFC_AVG_EN`.

Ports:
- `CLK`, in, 1: measurement clock; all counts are in `CLK` cycles.
- `RST_N`, in, 1: reset, asynchronous, active-high.
- `FREQ_IN`, in, `CHANNELS`: asynchronous inputs to be measured.
- `TIME_HIGH`, out, `CHANNELS*COUNTER_BITS`: last completed high-phase length per channel; channel k is at `[k*COUNTER_BITS +: COUNTER_BITS]`.
- `TIME_LOW`, out, `CHANNELS*COUNTER_BITS`: last completed low-phase length.
- `PERIOD`, out, `CHANNELS*(COUNTER_BITS+1)`: last completed rising-to-rising period.
- `PERIOD_AVG`, out, `CHANNELS*(COUNTER_BITS+1)`: averaged period.
- `VALID`, out, `CHANNELS`: `PERIOD` holds a full measurement.
- `STUCK`, out, `CHANNELS`: the current phase has saturated.
- `UPDATE`, out, `CHANNELS`: one-cycle pulse when `PERIOD` is written.
- `AVG_UPDATE`, out, `CHANNELS`: one-cycle pulse when `PERIOD_AVG` is written.

## Operation
- Each channel runs independently; the channels share no state.
- Input path: `SYNC_STAGES` flops, then an edge-detect register. A rise or fall is a change in the last synchronised bit.
- A phase counter clears to 1 on every detected edge, then increments by 1 per cycle, saturating at 2^`COUNTER_BITS`−1.
- On a falling edge: `TIME_HIGH` ← counter value.
- On a rising edge: `TIME_LOW` ← counter value, and `PERIOD` ← (`TIME_HIGH` + counter value), computed with 1 extra bit so it never wraps.
- Per-channel FSM (encoding defined in the package):
  - INIT: after reset. Counting is suppressed; all edges are ignored except the first. The first edge moves to ARMED.
  - ARMED: phase lengths are measured and `TIME_HIGH`/`TIME_LOW` are written. The first rising edge that follows a completed high phase and a completed low phase writes `PERIOD`, pulses `UPDATE`, sets `VALID`, and moves to RUN.
  - RUN: every rising edge writes `PERIOD` and pulses `UPDATE`.
- Stuck detection: when the counter reaches saturation, `STUCK` is set and `VALID` is cleared. On the next edge, `STUCK` clears, the state falls back to ARMED, and the saturated phase value is still written to `TIME_HIGH` or `TIME_LOW`.
- Simultaneous edges on different channels are fully independent; none is lost.

## Timing
- Reset values: every output bus is 0, and `VALID`, `STUCK`, `UPDATE` and `AVG_UPDATE` are 0. All FSMs are in INIT.
- Latency: an output changes `SYNC_STAGES`+1 `CLK` edges after the raw input edge is first sampled.
- `UPDATE` is high in the same cycle `PERIOD` takes its new value.
- Reset mid-measurement: all counts are discarded immediately (asynchronous) and no `UPDATE` pulse is issued. Measurement restarts from INIT after `RST_N` deasserts.
- A phase shorter than 1 synchronised cycle is not resolved; glitches filtered out by the synchroniser produce no update.

## Configuration
- `MCFC_AVG_EN` defined:
  - Each channel accumulates 2^`AVG_LOG2` consecutive `PERIOD` values in an accumulator of width `COUNTER_BITS`+1+`AVG_LOG2`.
  - After the last value, `PERIOD_AVG` ← accumulator >> `AVG_LOG2` (truncating), `AVG_UPDATE` pulses, and the accumulator clears.
  - The accumulator also clears when `STUCK` rises.
- `MCFC_AVG_EN` undefined:
  - No accumulator logic is built.
  - `PERIOD_AVG` mirrors `PERIOD` and `AVG_UPDATE` mirrors `UPDATE`.

## Structure
- Package `freq_counter_pkg` holds:
  - the channel FSM state enum (INIT, ARMED, RUN);
  - the synchroniser depth limits.
- Sub-module `freq_channel`: one channel containing the synchroniser, edge detect, phase counter, FSM and optional averager.
- The top level contains only a generate loop instantiating `freq_channel` and packing the outputs into the flat buses.

## Test plan
- Reset, then ch0 low for 5 cycles and high for 3 cycles, repeated → after the second rising edge: `TIME_LOW`=5, `TIME_HIGH`=3, `PERIOD`=8, `VALID[0]`=1, one `UPDATE[0]` pulse per period.
- First edge after reset → no `UPDATE` pulse, `VALID`=0. A full period is required before `VALID` sets.
- `COUNTER_BITS`=8, ch1 held high for 300 cycles → `STUCK[1]` rises 255 cycles after the edge and `VALID[1]` falls. On the next fall, `TIME_HIGH`=255 and `STUCK[1]` clears.
- All 4 channels toggled on the same `CLK` with periods 4, 6, 10 and 20 → each channel reports its own `PERIOD` with no cross-talk.
- `RST_N` pulsed mid-high-phase on a channel in RUN → all outputs are 0 immediately and no `UPDATE` occurs until a new full period completes.
- `MCFC_AVG_EN` defined, `AVG_LOG2`=2, periods 8, 10, 8, 10 → `PERIOD_AVG`=9 with one `AVG_UPDATE`. Undefined → `PERIOD_AVG` tracks 8, 10, 8, 10.
